// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready inter-stage register with optional
// 2-entry skid buffer, synchronous flush and saturating stall counter.
module pipe_stage_reg #(
  parameter int                DATA_W    = 32,
  parameter int                SKID      = 1,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // state bits are {main_v, skid_v}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t            st_q;
  state_t            st_n;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_n;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_n;
  logic              rdy_q;
  logic              acc;
  logic              pop;

  assign out_valid = st_q[1];
  assign out_data  = main_q;
  assign in_ready  = (SKID != 0) ? rdy_q
                                 : (!st_q[1] || out_ready);
  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;

  always_comb begin
    st_n   = st_q;
    main_n = main_q;
    skid_n = skid_q;
    if (flush) begin
      st_n   = EMPTY;
      main_n = FLUSH_VAL;
      skid_n = FLUSH_VAL;
    end else begin
      unique case (st_q)
        EMPTY: begin
          if (acc) begin
            main_n = in_data;
            st_n   = ONE;
          end
        end
        ONE: begin
          unique case (1'b1)
            acc && pop: main_n = in_data;
            acc && !pop: begin
              skid_n = in_data;
              st_n   = FULL;
            end
            pop && !acc: st_n = EMPTY;
            default: st_n = ONE;
          endcase
        end
        FULL: begin
          if (pop) begin
            main_n = skid_q;
            st_n   = ONE;
          end
        end
        default: st_n = EMPTY;
      endcase
    end
  end

  // rdy_q mirrors !skid_v so in_ready has no combinational input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= EMPTY;
      main_q <= FLUSH_VAL;
      skid_q <= FLUSH_VAL;
      rdy_q  <= 1'b1;
    end else begin
      st_q   <= st_n;
      main_q <= main_n;
      skid_q <= skid_n;
      rdy_q  <= (st_n != FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid and flat variants share stimulus,
// each checked by a queue-based reference model at the falling edge.
module tb_pipe_stage_reg;

  localparam logic [7:0] FV = 8'hE5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       rdy0, rdy1, ov0, ov1;
  logic [7:0] od0, od1;
  logic [1:0] sc0;
  logic [7:0] sc1;

  int   total = 0;
  int   bad = 0;
  logic armed = 1'b0;

  logic [7:0] sb[2][$];
  int         stalls[2] = '{0, 0};
  int         cmax[2]   = '{3, 255};
  logic [7:0] idle[2]   = '{FV, FV};

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(8), .SKID(1), .FLUSH_VAL(FV), .CNT_W(2)
  ) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .stall_cnt(sc0)
  );

  pipe_stage_reg #(
    .DATA_W(8), .SKID(0), .FLUSH_VAL(FV), .CNT_W(8)
  ) u_flat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .stall_cnt(sc1)
  );

  task automatic chk(input string nm, input int k,
                     input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h at %0t",
               nm, k, got, exp, $time);
    end
  endtask

  // Reference: a FIFO of accepted payloads; capacity 2 (skid) or 1 (flat)
  task automatic model(input int k, input logic rdy, input logic ov,
                       input logic [7:0] od, input logic [31:0] sc);
    bit v, er, acc, pop;
    v  = sb[k].size() > 0;
    er = (k == 0) ? (sb[k].size() < 2) : (!v || out_ready);
    chk("out_valid", k, 32'(ov), 32'(v));
    chk("in_ready", k, 32'(rdy), 32'(er));
    chk("stall_cnt", k, sc, 32'(stalls[k]));
    if (v) chk("out_data", k, 32'(od), 32'(sb[k][0]));
    else   chk("idle_data", k, 32'(od), 32'(idle[k]));
    acc = in_valid && er;
    pop = v && out_ready;
    if (!rst_n) begin
      sb[k].delete();
      stalls[k] = 0;
      idle[k]   = FV;
    end else begin
      if (v && !out_ready && stalls[k] < cmax[k]) stalls[k]++;
      if (pop) idle[k] = sb[k].pop_front();
      if (flush) begin
        sb[k].delete();
        idle[k] = FV;
      end else if (acc) begin
        sb[k].push_back(in_data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      model(0, rdy0, ov0, od0, 32'(sc0));
      model(1, rdy1, ov1, od1, 32'(sc1));
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d,
                     input logic r, input logic f,
                     input logic rs = 1'b1);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    rst_n     = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_data = 8'h00;
    @(posedge clk);
    #1;
    armed = 1'b1;
    cyc(0, 8'h00, 0, 0, 0);
    chk("rst_ready", 0, 32'(rdy0), 32'd1);
    chk("rst_data", 0, 32'(od0), 32'(FV));

    // streaming at full rate
    cyc(1, 8'h11, 1, 0);
    cyc(1, 8'h22, 1, 0);
    cyc(1, 8'h33, 1, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);

    // skid fill under back-pressure, then drain
    cyc(1, 8'h11, 1, 0);
    cyc(1, 8'h22, 0, 0);
    chk("skid_full_rdy", 0, 32'(rdy0), 32'd0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    chk("stall3", 0, 32'(sc0), 32'd3);
    chk("stall_data", 0, 32'(od0), 32'h11);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);

    // flush while FULL with a same-cycle pop
    cyc(0, 8'h00, 0, 0, 0);
    cyc(1, 8'h0A, 0, 0);
    cyc(1, 8'h0B, 0, 0);
    cyc(0, 8'h00, 1, 1);
    chk("flush_v", 0, 32'(ov0), 32'd0);
    chk("flush_d", 0, 32'(od0), 32'(FV));
    chk("flush_rdy", 0, 32'(rdy0), 32'd1);
    cyc(0, 8'h00, 1, 0);

    // flush discards a same-cycle accept
    cyc(1, 8'h44, 0, 0);
    cyc(1, 8'h55, 0, 1);
    chk("flush_acc", 0, 32'(ov0), 32'd0);
    cyc(0, 8'h00, 1, 0);

    // counter saturation, flush-immunity, reset clear
    cyc(0, 8'h00, 0, 0, 0);
    cyc(1, 8'h66, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 8'h00, 0, 0);
    chk("sat", 0, 32'(sc0), 32'd3);
    chk("cnt6", 1, 32'(sc1), 32'd6);
    cyc(0, 8'h00, 0, 1);
    chk("sat_flush", 0, 32'(sc0), 32'd3);
    chk("cnt_flush", 1, 32'(sc1), 32'd7);
    cyc(1, 8'h77, 0, 0);
    cyc(1, 8'h78, 1, 0, 0);
    chk("rst_cnt", 0, 32'(sc0), 32'd0);
    chk("rst_v", 1, 32'(ov1), 32'd0);
    chk("rst_d", 1, 32'(od1), 32'(FV));

    // flat variant: combinational in_ready
    cyc(1, 8'h70, 0, 0);
    cyc(0, 8'h00, 0, 0);
    chk("flat_block", 1, 32'(rdy1), 32'd0);
    in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    #1;
    chk("flat_comb", 1, 32'(rdy1), 32'd1);
    @(posedge clk);
    #1;
    chk("flat_77", 1, 32'(od1), 32'h77);

    // sustained throughput
    for (int i = 0; i < 200; i++) cyc(1, 8'($urandom), 1, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom),
          $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 299) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
